// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, responder FSM states and the
// slave-select encodings used by the master-side decode.
package spi_pkg;

    localparam int SPI_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        TRIG = 3'b000,
        CH1  = 3'b001,
        CH2  = 3'b010,
        CH3  = 3'b011,
        EEP  = 3'b100
    } ss_sel_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchronizer for an asynchronous input with one-clk-wide
// rise/fall strobes; reset value chosen so an idle line produces no edge.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RST_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    // sync_q[1] is the metastability-filtered level, sync_q[2] its previous value.
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// Oversampled SPI responder: captures a WIDTH-bit command from MOSI and
// returns a preloaded response word on MISO, all in the clk domain.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    output logic             MISO_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt,
    output logic [WIDTH-1:0] cmd_rcvd,
    output logic             rdy,
    input  logic             clr_rdy,
    output logic             frame_err,
    output logic             ovr
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    logic             ss_rise;
    logic             ss_fall;
    logic             sclk_rise;
    logic             sclk_fall;
    logic [2:0]       mosi_q;
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] rx_shift;
    logic [WIDTH-1:0] rx_next;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] tx_buf;

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (SS_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Third MOSI flop lines the data bit up with the sclk_rise strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_q <= '0;
        end else begin
            mosi_q <= {mosi_q[1:0], MOSI};
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        cnt_next = bit_cnt;
        rx_next  = rx_shift;
        if (sclk_rise) begin
            rx_next = {rx_shift[WIDTH-2:0], mosi_q[2]};
            if (bit_cnt != CNT_SAT) begin
                cnt_next = bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            tx_buf    <= '0;
            cmd_rcvd  <= '0;
            rdy       <= 1'b0;
            MISO_oe   <= 1'b0;
            frame_err <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            ovr       <= 1'b0;
            if (wrt) begin
                tx_buf <= tx_data;
            end
            if (clr_rdy) begin
                rdy <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        rx_shift <= '0;
                        tx_shift <= wrt ? tx_data : tx_buf;
                        bit_cnt  <= '0;
                        MISO_oe  <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    rx_shift <= rx_next;
                    bit_cnt  <= cnt_next;
                    // The master's leading fall (count still 0) must not shift,
                    // or the MSB would never be sampled.
                    if (sclk_fall && bit_cnt != '0) begin
                        tx_shift <= tx_shift << 1;
                    end
                    if (ss_rise) begin
                        MISO_oe <= 1'b0;
                        state   <= IDLE;
                        if (cnt_next == CNT_FULL) begin
                            cmd_rcvd <= rx_next;
                            rdy      <= 1'b1;
                            ovr      <= rdy;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MISO = (state == SHIFT) & tx_shift[WIDTH-1];

endmodule
